// File: rtl/mem_io_pkg.sv
// Shared decode constants and target enumeration for the data-side memory/IO stage.
package mem_io_pkg;

  localparam logic [3:0] REGION_DMEM = 4'h0;
  localparam logic [3:0] REGION_IO   = 4'hF;

  // IO register offsets, as word index mem_addr[7:2]
  localparam logic [5:0] IO_LED    = 6'h00;
  localparam logic [5:0] IO_SW     = 6'h01;
  localparam logic [5:0] IO_CYCLES = 6'h02;
  localparam logic [5:0] IO_TLOAD  = 6'h03;
  localparam logic [5:0] IO_TSTAT  = 6'h04;

  typedef enum logic [2:0] {
    T_NONE,
    T_DMEM,
    T_LED,
    T_SW,
    T_CYC,
    T_TLOAD,
    T_TSTAT
  } target_t;

endpackage

// File: rtl/mem_io_if.sv
// Core-side data bus: address, write strobe, write data and same-cycle read data.
interface mem_io_if;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  modport master (output mem_addr, output mem_wr, output mem_writedata, input mem_readdata);
  modport slave  (input mem_addr, input mem_wr, input mem_writedata, output mem_readdata);
endinterface

// File: rtl/mem_io_unit_io_timer.sv
// Prescaled countdown timer with a sticky expired flag.
module io_timer #(
  parameter int TIMER_DIV = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_we,
  input  logic [31:0] load_val,
  input  logic        clr_we,
  output logic [31:0] count,
  output logic        expired,
  output logic        running
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          hit_zero;

  assign running  = (count != '0);
  assign tick     = running && (presc == PRESC_MAX);
  // A load on the final decrement edge replaces the count, so no expiry.
  assign hit_zero = tick && (count == 32'd1) && !load_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      if (load_we) begin
        count <= load_val;
        presc <= '0;
      end else if (running) begin
        if (tick) begin
          presc <= '0;
          count <= count - 32'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      // Expiry beats a simultaneous clear so the event is never lost.
      if (hit_zero)
        expired <= 1'b1;
      else if (clr_we)
        expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_io_unit.sv
// Data memory plus LED/switch/cycle-counter/timer registers behind the core's data bus.
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int DMEM_WORDS = 64,
  parameter int NUM_LEDS   = 16,
  parameter int NUM_SW     = 16,
  parameter int TIMER_DIV  = 100
) (
  input  logic                clk,
  input  logic                reset,
  mem_io_if.slave             bus,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_LEDS-1:0] led,
  output logic                timer_irq
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]       dmem [DMEM_WORDS];
  logic [AW-1:0]     dmem_idx;
  target_t           tgt;
  logic [NUM_SW-1:0] sw_meta;
  logic [NUM_SW-1:0] sw_sync;
  logic [31:0]       cycles;
  logic [31:0]       t_count;
  logic              t_expired;
  logic              t_running;
  logic              unused_bits;

  assign dmem_idx    = bus.mem_addr[AW+1:2];
  assign unused_bits = ^{bus.mem_addr, bus.mem_writedata};

  always_comb begin
    tgt = T_NONE;
    if (bus.mem_addr[31:28] == REGION_DMEM) begin
      tgt = T_DMEM;
    end else if (bus.mem_addr[31:28] == REGION_IO) begin
      case (bus.mem_addr[7:2])
        IO_LED:    tgt = T_LED;
        IO_SW:     tgt = T_SW;
        IO_CYCLES: tgt = T_CYC;
        IO_TLOAD:  tgt = T_TLOAD;
        IO_TSTAT:  tgt = T_TSTAT;
        default:   tgt = T_NONE;
      endcase
    end
  end

  // DMEM has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.mem_wr && tgt == T_DMEM)
      dmem[dmem_idx] <= bus.mem_writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      cycles  <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (bus.mem_wr && tgt == T_LED)
        led <= bus.mem_writedata[NUM_LEDS-1:0];
      if (bus.mem_wr && tgt == T_CYC)
        cycles <= '0;
      else
        cycles <= cycles + 32'd1;
    end
  end

  io_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_we  (bus.mem_wr && tgt == T_TLOAD),
    .load_val (bus.mem_writedata),
    .clr_we   (bus.mem_wr && tgt == T_TSTAT),
    .count    (t_count),
    .expired  (t_expired),
    .running  (t_running)
  );

  assign timer_irq = t_expired;

  always_comb begin
    bus.mem_readdata = '0;
    case (tgt)
      T_DMEM:  bus.mem_readdata = dmem[dmem_idx];
      T_LED:   bus.mem_readdata = 32'(led);
      T_SW:    bus.mem_readdata = 32'(sw_sync);
      T_CYC:   bus.mem_readdata = cycles;
      T_TLOAD: bus.mem_readdata = t_count;
      T_TSTAT: bus.mem_readdata = {30'd0, t_running, t_expired};
      default: bus.mem_readdata = '0;
    endcase
  end

endmodule

// File: doc/mem_io_unit.md
Name: mem_io_unit

Overview:
- Data-side memory/IO stage directly downstream of the single-cycle MIPS core.
- Consumes the core's mem_addr, mem_wr and mem_writedata; returns mem_readdata in the same cycle.
- Decodes addresses into a word-addressed data RAM plus a small peripheral register file: LED register, synchronized switches, cycle counter, countdown timer.
- Sits beside instruction memory in the top-level.

Parameters:
DMEM_WORDS, 64, data RAM depth in 32-bit words (power of two)
NUM_LEDS, 16, width of LED output register
NUM_SW, 16, width of switch input
TIMER_DIV, 100, clk cycles per timer decrement (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
mem_addr  input  32  byte address from core; bits [1:0] ignored
mem_wr  input  1  write strobe, sampled on rising clk
mem_writedata  input  32  write data from core
mem_readdata  output  32  combinational read data for current mem_addr
sw  input  NUM_SW  asynchronous switch inputs
led  output  NUM_LEDS  LED register contents
timer_irq  output  1  equals timer expired flag

Behaviour:
- Address decode:
  - mem_addr[31:28]==4'h0 selects DMEM; word index = mem_addr[log2(DMEM_WORDS)+1:2]; upper index bits aliased.
  - mem_addr[31:28]==4'hF selects IO, decoded on mem_addr[7:2].
  - Any other region: read 0, write ignored.
- IO map:
  - 0xFFFF_0000 LED, RW; read zero-extended.
  - 0xFFFF_0004 SW, RO; value from 2-flop synchronizer.
  - 0xFFFF_0008 CYCLES, RO; any write clears.
  - 0xFFFF_000C TLOAD; write loads countdown; read returns current count.
  - 0xFFFF_0010 TSTAT; bit0 expired (sticky), bit1 running (count!=0); any write clears expired.
  - Unmapped IO offsets: read 0, write ignored.
- Reads: purely combinational from mem_addr, zero latency; IO registers read their pre-edge value.
- Writes: take effect at the rising edge where mem_wr=1; a read of the same address in the next cycle returns the new value.
- Reset (reset=0, async):
  - led=0, sync flops=0, CYCLES=0, count=0, prescaler=0, expired=0, timer_irq=0.
  - DMEM contents are not reset.
  - mem_readdata follows the decode: 0 for IO registers that reset to 0.
- CYCLES: +1 every clk, wraps 0xFFFF_FFFF->0. On a clear write the next value is 0 (clear wins over increment).
- Timer:
  - Prescaler counts 0..TIMER_DIV-1 while count!=0; count decrements when the prescaler reaches TIMER_DIV-1.
  - Count 1->0 sets expired and the timer stops.
  - A TLOAD write sets count=mem_writedata and prescaler=0. Loading 0 stops the timer without setting expired.
- Simultaneous events:
  - TLOAD write in the same cycle as a 1->0 decrement: load wins, expired not set.
  - TSTAT clear in the same cycle as expiry: set wins, expired stays 1.
- Reset asserted mid-count aborts the timer immediately. No expiry is generated.
- mem_wr with an out-of-range region: no state changes anywhere.

Decomposition:
- Package mem_io_pkg:
  - region constants (REGION_DMEM=4'h0, REGION_IO=4'hF);
  - IO offset localparams (IO_LED, IO_SW, IO_CYCLES, IO_TLOAD, IO_TSTAT);
  - enum typedef for the decoded target (T_NONE, T_DMEM, T_LED, T_SW, T_CYC, T_TLOAD, T_TSTAT).
- Sub-module io_timer:
  - contains prescaler, countdown and expired flag;
  - ports: clk, reset, load_we, load_val, clr_we, count, expired, running.
- The parent holds the decode, DMEM array, LED register, switch synchronizer, cycle counter and read mux.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010 and 0x1234_5678 to 0x0000_0014. Read back both: values match. DMEM_WORDS=64 aliasing: read 0x0000_0110 returns 0xDEADBEEF.
- Write 0x0000_A5A5 to 0xFFFF_0000: led=16'hA5A5 after the edge. Set sw=16'h00FF: the read of 0xFFFF_0004 returns 0x0000_00FF two cycles later, not earlier.
- Read CYCLES at N and at N+10: difference is 10. Write CYCLES: next-cycle read is 0.
- Force the CYCLES wrap via hierarchical force to 0xFFFF_FFFF: next read is 0.
- TIMER_DIV=4, load 3:
  - timer_irq rises exactly 12 cycles after the load edge;
  - TSTAT reads 0x1; CYCLES keeps running;
  - write TSTAT: timer_irq=0 next cycle.
- Boundary cases:
  - Load 1 and clear TSTAT on the expiry cycle: expired=1.
  - Reload 5 on the expiry cycle: expired=0, running=1.
  - Load 0: running=0, no irq.
  - Assert reset mid-count: count=0, irq=0.
